// File: rtl/serv_alu_pkg.sv
// Shared encodings for the bit-serial ALU/MAC: opcodes, FSM states, XLEN and beat count.
package serv_alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_OR   = 3'd5,
    ALU_AND  = 3'd6,
    ALU_MAC  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_MUL    = 2'd2,
    ST_DRAIN  = 2'd3
  } alu_state_e;

  function automatic int beats(input int w);
    return XLEN / w;
  endfunction

endpackage

// File: rtl/serv_alu_mul_seq.sv
// 32-cycle shift-add multiply engine: prod = acc_in + mcand * mplier (mod 2^32).
// done pulses on the final step cycle, with prod carrying that step's result.
module serv_alu_mul_seq
  import serv_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] mplier,
  input  logic [XLEN-1:0] acc_in,
  output logic            done,
  output logic [XLEN-1:0] prod
);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            run_q, run_d;
  logic [XLEN-1:0] step_s;

  assign step_s = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  assign done   = run_q && (cnt_q == 5'd31);
  assign prod   = step_s;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = mcand;
      mplier_d = mplier;
      prod_d   = acc_in;
      cnt_d    = 5'd0;
      run_d    = 1'b1;
    end else if (run_q) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prod_d   = step_s;
      cnt_d    = cnt_q + 5'd1;
      run_d    = (cnt_q != 5'd31);
    end else begin
      run_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      prod_q   <= {XLEN{1'b0}};
      cnt_q    <= 5'd0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/serv_alu_mac.sv
// W-bit-serial ALU; the i_start cycle is beat 0 of the stream. Define SERV_ALU_MAC_EN to build
// the MAC sequencer (operand capture, shift-add multiply, accumulator drain); otherwise op 7 is ADD.
module serv_alu_mac
  import serv_alu_pkg::*;
#(
  parameter int W = 1,
  parameter int B = W - 1
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [2:0] i_op,
  input  logic       i_acc_clr,
  input  logic [B:0] i_rs1,
  input  logic [B:0] i_op_b,
  output logic       o_busy,
  output logic [B:0] o_rd,
  output logic       o_rd_valid,
  output logic       o_cmp,
  output logic       o_done
);

  localparam int         BEATS     = beats(W);
  localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

  alu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  alu_op_e    op_q, op_d;

  logic       start_take_s, in_stream_s, beat_last_s, is_mac_s, sub_s, cin_s, cmp_s;
  logic [5:0] beat_idx_s;
  alu_op_e    cur_op_s, alu_op_s;
  logic [B:0] b_x_s, alu_res_s;
  logic [W:0] sum_s;

  assign start_take_s = (state_q == ST_IDLE) && i_start;
  assign in_stream_s  = start_take_s || (state_q == ST_STREAM);
  assign beat_idx_s   = start_take_s ? 6'd0 : cnt_q;
  assign beat_last_s  = (beat_idx_s == LAST_BEAT);
  assign cur_op_s     = start_take_s ? alu_op_e'(i_op) : op_q;

`ifdef SERV_ALU_MAC_EN
  assign is_mac_s = (cur_op_s == ALU_MAC);
  assign alu_op_s = cur_op_s;
`else
  logic unused_acc_clr_s;
  assign unused_acc_clr_s = i_acc_clr;
  assign is_mac_s = 1'b0;
  assign alu_op_s = (cur_op_s == ALU_MAC) ? ALU_ADD : cur_op_s;
`endif

  assign sub_s  = (alu_op_s == ALU_SUB) || (alu_op_s == ALU_SLT) || (alu_op_s == ALU_SLTU);
  assign cin_s  = start_take_s ? sub_s : carry_q;
  assign b_x_s  = i_op_b ^ {W{sub_s}};
  assign sum_s  = {1'b0, i_rs1} + {1'b0, b_x_s} + {{W{1'b0}}, cin_s};
  assign o_busy = (state_q != ST_IDLE);

  // Per-beat ALU result and compare, using the sign bits of the chunk on the wire.
  always_comb begin
    alu_res_s = {W{1'b0}};
    cmp_s     = 1'b0;
    case (alu_op_s)
      ALU_ADD, ALU_SUB: alu_res_s = sum_s[B:0];
      ALU_XOR:          alu_res_s = i_rs1 ^ i_op_b;
      ALU_OR:           alu_res_s = i_rs1 | i_op_b;
      ALU_AND:          alu_res_s = i_rs1 & i_op_b;
      ALU_SLT:          cmp_s = (i_rs1[B] != i_op_b[B]) ? i_rs1[B] : ~sum_s[W];
      ALU_SLTU:         cmp_s = ~sum_s[W];
      default:          alu_res_s = {W{1'b0}};
    endcase
  end

`ifdef SERV_ALU_MAC_EN
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [XLEN-1:0] acc_in_s, mul_prod_s;
  logic [B:0]      drain_word_s;
  logic            mul_start_s, mul_done_s;

  // A clear in IDLE takes effect before a MAC starting in the same cycle reads the accumulator.
  assign acc_in_s     = ((state_q == ST_IDLE) && i_acc_clr) ? {XLEN{1'b0}} : acc_q;
  assign drain_word_s = W'(acc_q >> (32'(cnt_q) * 32'(W)));
  assign mul_start_s  = in_stream_s && is_mac_s && beat_last_s;

  serv_alu_mul_seq u_mul (
    .clk    (clk),
    .rst    (i_rst),
    .start  (mul_start_s),
    .mcand  (mcand_d),
    .mplier (mplier_d),
    .acc_in (acc_in_s),
    .done   (mul_done_s),
    .prod   (mul_prod_s)
  );

  // Operand capture registers and accumulator.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      mcand_q  <= {XLEN{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      acc_q    <= {XLEN{1'b0}};
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`endif

  // FSM next state, stream bookkeeping and output selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    op_d       = op_q;
    o_rd       = {W{1'b0}};
    o_rd_valid = 1'b0;
    o_cmp      = 1'b0;
    o_done     = 1'b0;
`ifdef SERV_ALU_MAC_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_in_s;
`endif
    if (in_stream_s) begin
      carry_d = sum_s[W];
      op_d    = cur_op_s;
      if (is_mac_s) begin
`ifdef SERV_ALU_MAC_EN
        // Chunks enter at the top so chunk 0 ends up in the LSBs after BEATS shifts.
        mcand_d  = (mcand_q >> W) | (XLEN'(i_rs1) << (XLEN - W));
        mplier_d = (mplier_q >> W) | (XLEN'(i_op_b) << (XLEN - W));
`endif
      end else begin
        o_rd       = alu_res_s;
        o_rd_valid = 1'b1;
        o_done     = beat_last_s;
        o_cmp      = beat_last_s & cmp_s;
      end
      if (beat_last_s) begin
        cnt_d   = 6'd0;
        state_d = is_mac_s ? ST_MUL : ST_IDLE;
      end else begin
        cnt_d   = beat_idx_s + 6'd1;
        state_d = ST_STREAM;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
`ifdef SERV_ALU_MAC_EN
        ST_MUL: begin
          if (mul_done_s) begin
            acc_d   = mul_prod_s;
            cnt_d   = 6'd0;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_MUL;
          end
        end
        ST_DRAIN: begin
          o_rd       = drain_word_s;
          o_rd_valid = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            o_done  = 1'b1;
            cnt_d   = 6'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 6'd1;
          end
        end
`endif
        default: begin
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, beat counter, inter-beat carry and latched opcode.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      carry_q <= 1'b0;
      op_q    <= ALU_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_serv_alu_mac.sv
// Self-checking bench for serv_alu_mac at W=8 against a whole-word arithmetic reference model.
// Expectations follow SERV_ALU_MAC_EN: op 7 is MAC when defined, ADD otherwise.
module tb_serv_alu_mac;

  localparam int W     = 8;
  localparam int BEATS = 32 / W;
`ifdef SERV_ALU_MAC_EN
  localparam bit MAC_BUILD = 1'b1;
`else
  localparam bit MAC_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst, i_start, i_acc_clr;
  logic [2:0]   i_op;
  logic [W-1:0] i_rs1, i_op_b;
  logic         o_busy, o_rd_valid, o_cmp, o_done;
  logic [W-1:0] o_rd;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_m;

  always #5 clk = ~clk;

  serv_alu_mac #(.W(W)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_acc_clr(i_acc_clr),
    .i_rs1(i_rs1), .i_op_b(i_op_b), .o_busy(o_busy), .o_rd(o_rd),
    .o_rd_valid(o_rd_valid), .o_cmp(o_cmp), .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: {cmp, result}
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0, 3'd7: return {1'b0, a + b};
      3'd1:       return {1'b0, a - b};
      3'd2:       return {($signed(a) < $signed(b)), 32'h0};
      3'd3:       return {(a < b), 32'h0};
      3'd4:       return {1'b0, a ^ b};
      3'd5:       return {1'b0, a | b};
      3'd6:       return {1'b0, a & b};
      default:    return 33'h0;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit clr, input bit hold);
    logic [31:0] res;
    logic        cmp;
    logic [32:0] r;
    bit          mac;
    mac = MAC_BUILD && (op == 3'd7);
    if (clr) acc_m = 32'h0;
    if (mac) begin
      acc_m = acc_m + a * b;
      res   = acc_m;
      cmp   = 1'b0;
    end else begin
      r   = ref_alu(op, a, b);
      res = r[31:0];
      cmp = r[32];
    end
    @(posedge clk); #1;
    i_op      = op;
    i_acc_clr = clr;
    for (int k = 0; k < BEATS; k++) begin
      i_start = (k == 0) || hold;
      i_rs1   = a[k*W +: W];
      i_op_b  = b[k*W +: W];
      @(negedge clk);
      chk("busy_stream", 32'(o_busy), (k == 0) ? 32'd0 : 32'd1);
      chk("valid_stream", 32'(o_rd_valid), mac ? 32'd0 : 32'd1);
      chk("done_stream", 32'(o_done), (!mac && k == BEATS - 1) ? 32'd1 : 32'd0);
      chk("cmp_stream", 32'(o_cmp), (!mac && k == BEATS - 1) ? 32'(cmp) : 32'd0);
      if (!mac) chk("rd_stream", 32'(o_rd), 32'(res[k*W +: W]));
      @(posedge clk); #1;
      i_acc_clr = 1'b0;
    end
    if (mac) begin
      for (int c = 0; c < 32; c++) begin
        i_rs1  = W'($urandom);
        i_op_b = W'($urandom);
        @(negedge clk);
        chk("busy_mul", 32'(o_busy), 32'd1);
        chk("valid_mul", 32'(o_rd_valid), 32'd0);
        chk("done_mul", 32'(o_done), 32'd0);
        @(posedge clk); #1;
      end
      for (int k = 0; k < BEATS; k++) begin
        @(negedge clk);
        chk("valid_drain", 32'(o_rd_valid), 32'd1);
        chk("rd_drain", 32'(o_rd), 32'(res[k*W +: W]));
        chk("done_drain", 32'(o_done), (k == BEATS - 1) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
      end
    end
    i_start = 1'b0;
    @(negedge clk);
    chk("busy_after", 32'(o_busy), 32'd0);
    chk("valid_after", 32'(o_rd_valid), 32'd0);
    chk("done_after", 32'(o_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_acc_clr = 1'b0; i_op = 3'd0;
    i_rs1 = '0; i_op_b = '0; acc_m = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_cmp", 32'(o_cmp), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    i_rst = 1'b0;

    do_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op(3'd1, 32'd5, 32'd7, 1'b0, 1'b0);
    do_op(3'd2, 32'd5, 32'd7, 1'b0, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    do_op(3'd3, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    do_op(3'd4, 32'hA5A5_0F0F, 32'h5A5A_FF00, 1'b0, 1'b0);
    do_op(3'd5, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);
    do_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0);

    do_op(3'd7, 32'd3, 32'd4, 1'b1, 1'b0);
    do_op(3'd7, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    do_op(3'd7, $urandom, $urandom, 1'b0, 1'b1);
    do_op(3'd1, $urandom, $urandom, 1'b0, 1'b1);

    // Abort an op part-way through the multiply phase
    @(posedge clk); #1;
    i_op = 3'd7; i_start = 1'b1; i_rs1 = W'($urandom); i_op_b = W'($urandom);
    repeat (BEATS + 5) begin
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    i_rst = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_valid", 32'(o_rd_valid), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    acc_m = 32'h0;
    do_op(3'd0, $urandom, $urandom, 1'b0, 1'b0);
    do_op(3'd7, 32'h0, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
